// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: drives the register file's single write port from two sources.
//   - In-order pipeline writeback: has priority, no back-pressure.
//   - MDU result stream: valid/ready handshake, buffered in a small in-order FIFO.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   pipe_valid/pipe_rd/pipe_data pipeline result (always accepted)
//   mdu_valid/mdu_ready          MDU handshake; mdu_ready = FIFO not full
//   mdu_rd/mdu_data              MDU result destination and value
//   rd_we/rd_waddr/rd_wdata      registered register-file write port
//   busy_mask                    one bit per register with a buffered MDU write
//   stall_o                      asks the pipeline to hold pipe_valid low this cycle
module rf_wb_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pipe_valid,
  input  logic [ADDR_W-1:0]      pipe_rd,
  input  logic [DATA_W-1:0]      pipe_data,
  input  logic                   mdu_valid,
  output logic                   mdu_ready,
  input  logic [ADDR_W-1:0]      mdu_rd,
  input  logic [DATA_W-1:0]      mdu_data,
  output logic                   rd_we,
  output logic [ADDR_W-1:0]      rd_waddr,
  output logic [DATA_W-1:0]      rd_wdata,
  output logic [2**ADDR_W-1:0]   busy_mask,
  output logic                   stall_o
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);

  // FIFO storage and bookkeeping. FIFO_DEPTH is a power of two, so the
  // pointers wrap naturally.
  logic [ADDR_W-1:0] rd_mem_q   [FIFO_DEPTH];
  logic [DATA_W-1:0] data_mem_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] valid_q, valid_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;

  logic [CntW-1:0] starve_q, starve_d;

  logic              rd_we_q, rd_we_d;
  logic [ADDR_W-1:0] rd_waddr_q, rd_waddr_d;
  logic [DATA_W-1:0] rd_wdata_q, rd_wdata_d;

  logic fifo_full, fifo_empty;
  logic mdu_fire, push, pop, pipe_win;

  assign fifo_full  = &valid_q;
  assign fifo_empty = ~|valid_q;

  // Ready depends only on state: no bypass, a full FIFO refuses even when popping.
  assign mdu_ready = ~fifo_full;
  assign mdu_fire  = mdu_valid & mdu_ready;
  // Writes to x0 complete the handshake but are discarded.
  assign push      = mdu_fire & (mdu_rd != '0);

  // A pipeline result to x0 is an idle pipeline and lets the FIFO head through.
  assign pipe_win = pipe_valid & (pipe_rd != '0);
  assign pop      = ~pipe_win & ~fifo_empty;

  // FIFO pointer / occupancy next state. A push never targets the slot being
  // popped: push requires a free slot, pop requires the head slot be valid.
  always_comb begin
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PtrW'(1);
    end
  end

  // Output port next state: hold address/data when nothing wins.
  always_comb begin
    rd_we_d    = 1'b0;
    rd_waddr_d = rd_waddr_q;
    rd_wdata_d = rd_wdata_q;
    if (pipe_win) begin
      rd_we_d    = 1'b1;
      rd_waddr_d = pipe_rd;
      rd_wdata_d = pipe_data;
    end else if (pop) begin
      rd_we_d    = 1'b1;
      rd_waddr_d = rd_mem_q[rd_ptr_q];
      rd_wdata_d = data_mem_q[rd_ptr_q];
    end
  end

  // Starvation counter: counts cycles a waiting head was passed over.
  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || pop) begin
      starve_d = '0;
    end else if (starve_q != CntW'(STARVE_MAX)) begin
      starve_d = starve_q + CntW'(1);
    end
  end

  assign stall_o = (starve_q == CntW'(STARVE_MAX));

  // Busy mask: OR of one-hot destinations of every valid entry.
  always_comb begin
    busy_mask = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (valid_q[i]) begin
        busy_mask[rd_mem_q[i]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      starve_q   <= '0;
      rd_we_q    <= 1'b0;
      rd_waddr_q <= '0;
      rd_wdata_q <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        rd_mem_q[i]   <= '0;
        data_mem_q[i] <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      starve_q   <= starve_d;
      rd_we_q    <= rd_we_d;
      rd_waddr_q <= rd_waddr_d;
      rd_wdata_q <= rd_wdata_d;
      if (push) begin
        rd_mem_q[wr_ptr_q]   <= mdu_rd;
        data_mem_q[wr_ptr_q] <= mdu_data;
      end
    end
  end

  assign rd_we    = rd_we_q;
  assign rd_waddr = rd_waddr_q;
  assign rd_wdata = rd_wdata_q;

  // The pipeline must honour stall_o; if it does not, it still wins arbitration.
  a_no_pipe_during_stall: assert property (@(posedge clk) disable iff (rst)
    !(stall_o && pipe_valid));

endmodule
